minmax_tracker: RTL and testbench

//  Streaming consumer of less-than comparisons: accepts N-bit samples over a

---
 rtl/minmax_pkg.sv | 20 ++
 rtl/minmax_tracker_if.sv | 30 +++
 rtl/adder_n.sv | 16 +
 rtl/slt_unit.sv | 37 +++
 rtl/minmax_tracker.sv | 109 ++++++++++
 tb/tb_minmax_tracker.sv | 188 ++++++++++++++++++
 6 files changed

// File: rtl/minmax_pkg.sv
// Shared types for the min/max frame tracker.
package minmax_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    typedef enum logic {
        UNS = 1'b0,
        SGN = 1'b1
    } cmp_mode_t;

    // Map the per-sample signedness flag onto the compare mode.
    function automatic cmp_mode_t mode_from_flag(input logic is_signed);
        return is_signed ? SGN : UNS;
    endfunction

endpackage : minmax_pkg

// File: rtl/minmax_tracker_if.sv
// Sample input stream and frame-result output stream of the min/max tracker.
interface minmax_tracker_if #(
    parameter int unsigned N  = 32,
    parameter int unsigned CW = 4
);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic          in_signed;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_min;
    logic [N-1:0]  out_max;
    logic [CW-1:0] out_count;

    // Sample producer / result consumer side.
    modport master (
        output in_valid, in_data, in_signed, in_last, out_ready,
        input  in_ready, out_valid, out_min, out_max, out_count
    );

    // Tracker side.
    modport slave (
        input  in_valid, in_data, in_signed, in_last, out_ready,
        output in_ready, out_valid, out_min, out_max, out_count
    );

endinterface : minmax_tracker_if

// File: rtl/adder_n.sv
// W-bit adder with carry-in; the carry-out is not needed by its users.
module adder_n #(
    parameter int unsigned W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum_c
);

    // Plain sum; synthesis picks the adder architecture.
    always_comb begin
        sum_c = a + b + W'(cin);
    end

endmodule : adder_n

// File: rtl/slt_unit.sv
// Combinational a<b with selectable signed/unsigned ordering.
module slt_unit
    import minmax_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  cmp_mode_t    mode,
    output logic         lt_c
);

    logic [N:0] a_x;
    logic [N:0] b_n;
    logic [N:0] diff_c;
    logic       diff_unused_c;

    // Extend to N+1 bits so the subtract can never overflow; invert b for a-b.
    always_comb begin
        a_x = {((mode == SGN) ? a[N-1] : 1'b0), a};
        b_n = ~{((mode == SGN) ? b[N-1] : 1'b0), b};
    end

    adder_n #(
        .W (N + 1)
    ) u_sub (
        .a     (a_x),
        .b     (b_n),
        .cin   (1'b1),
        .sum_c (diff_c)
    );

    // The sign of the widened difference is the less-than result.
    assign lt_c          = diff_c[N];
    assign diff_unused_c = ^diff_c[N-1:0];

endmodule : slt_unit

// File: rtl/minmax_tracker.sv
// Tracks the running min and max of each sample frame and emits one result per frame.
module minmax_tracker
    import minmax_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned FRAME = 8
) (
    input  logic              clk,
    input  logic              rst,
    minmax_tracker_if.slave   bus
);

    localparam int unsigned CW = $clog2(FRAME + 1);

    state_t        state_q,     state_d;
    logic [N-1:0]  min_q,       min_d;
    logic [N-1:0]  max_q,       max_d;
    logic [CW-1:0] count_q,     count_d;
    cmp_mode_t     mode_q,      mode_d;
    logic          in_ready_q,  in_ready_d;
    logic          out_valid_q, out_valid_d;

    logic accept_c;
    logic lt_min_c;
    logic lt_max_c;
    logic frame_full_c;

    // New sample below current minimum.
    slt_unit #(.N(N)) u_slt_min (
        .a    (bus.in_data),
        .b    (min_q),
        .mode (mode_q),
        .lt_c (lt_min_c)
    );

    // Current maximum below new sample.
    slt_unit #(.N(N)) u_slt_max (
        .a    (max_q),
        .b    (bus.in_data),
        .mode (mode_q),
        .lt_c (lt_max_c)
    );

    // Next-state, datapath and handshake decode.
    always_comb begin
        state_d      = state_q;
        min_d        = min_q;
        max_d        = max_q;
        count_d      = count_q;
        mode_d       = mode_q;
        accept_c     = bus.in_valid & in_ready_q;
        frame_full_c = ((count_q + CW'(1)) == CW'(FRAME));

        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    min_d   = bus.in_data;
                    max_d   = bus.in_data;
                    count_d = CW'(1);
                    mode_d  = mode_from_flag(bus.in_signed);
                    state_d = (bus.in_last || (FRAME == 1)) ? EMIT : ACCUM;
                end
            end
            ACCUM: begin
                if (accept_c) begin
                    if (lt_min_c) min_d = bus.in_data;
                    if (lt_max_c) max_d = bus.in_data;
                    count_d = count_q + CW'(1);
                    if (bus.in_last || frame_full_c) state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_valid_q && bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d != EMIT);
        out_valid_d = (state_d == EMIT);
    end

    // State and result registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            min_q       <= '0;
            max_q       <= '0;
            count_q     <= '0;
            mode_q      <= UNS;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            min_q       <= min_d;
            max_q       <= max_d;
            count_q     <= count_d;
            mode_q      <= mode_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_min   = min_q;
    assign bus.out_max   = max_q;
    assign bus.out_count = count_q;

endmodule : minmax_tracker

// File: tb/tb_minmax_tracker.sv
// Directed bench for minmax_tracker (N=32, FRAME=8).
module tb_minmax_tracker;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    minmax_tracker_if #(.N(32), .CW(4)) bus ();

    minmax_tracker #(.N(32), .FRAME(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Offer one sample starting at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [31:0] d, input logic s, input logic l);
        int n;
        n = 0;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_signed = s;
        bus.in_last   = l;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Wait for a result, check it, complete the handshake.
    task automatic expect_result(input string tag, input logic [31:0] emin,
                                 input logic [31:0] emax, input logic [31:0] ecnt);
        int n;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_min"},   bus.out_min,        emin);
        check({tag, "_max"},   bus.out_max,        emax);
        check({tag, "_count"}, 32'(bus.out_count), ecnt);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_done"},  32'(bus.out_valid), 32'd0);
    endtask

    logic [31:0] t1 [8];
    logic [31:0] b2b_data [12];
    logic        b2b_last [12];
    logic [31:0] b2b_exp  [3][3];

    initial begin
        int idx, nres, bubbles, cyc;
        checks = 0;
        errors = 0;
        t1 = '{32'd5, 32'hFFFF_FFFF, 32'd0, 32'd7, 32'd7, 32'd3, 32'd1, 32'd2};
        b2b_data = '{32'd3, 32'd1, 32'd2,
                     32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1,
                     32'd100};
        b2b_last = '{1'b0, 1'b0, 1'b1,
                     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                     1'b1};
        b2b_exp  = '{'{32'd1, 32'd3, 32'd3}, '{32'd1, 32'd8, 32'd8}, '{32'd100, 32'd100, 32'd1}};

        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_signed = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        #3;
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_min",       bus.out_min,        32'd0);
        check("rst_max",       bus.out_max,        32'd0);
        check("rst_count",     32'(bus.out_count), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);

        // 1: unsigned full frame
        for (int i = 0; i < 8; i++) send(t1[i], 1'b0, 1'b0);
        expect_result("uns", 32'd0, 32'hFFFF_FFFF, 32'd8);

        // 2: signed full frame, in_signed flipped after the first sample
        send(t1[0], 1'b1, 1'b0);
        for (int i = 1; i < 8; i++) send(t1[i], 1'b0, 1'b0);
        expect_result("sgn", 32'hFFFF_FFFF, 32'd7, 32'd8);

        // 3: early close with signed extremes
        send(32'h8000_0000, 1'b1, 1'b0);
        send(32'h7FFF_FFFF, 1'b1, 1'b0);
        send(32'h0000_0000, 1'b1, 1'b1);

        // 4: hold the result under backpressure while a sample is offered
        check("bp_valid0", 32'(bus.out_valid), 32'd1);
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h55;
        bus.in_signed = 1'b0;
        bus.in_last   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_ready", 32'(bus.in_ready),  32'd0);
            check("bp_min",   bus.out_min,        32'h8000_0000);
            check("bp_max",   bus.out_max,        32'h7FFF_FFFF);
            check("bp_count", 32'(bus.out_count), 32'd3);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_rel_valid", 32'(bus.out_valid), 32'd0);
        check("bp_rel_ready", 32'(bus.in_ready),  32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        expect_result("bp_next", 32'h55, 32'h55, 32'd1);

        // 5: reset in the middle of a frame
        for (int i = 0; i < 4; i++) send(32'(i + 1), 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_ready", 32'(bus.in_ready),  32'd0);
        check("mid_rst_count", 32'(bus.out_count), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_valid", 32'(bus.out_valid), 32'd0);
        end
        send(32'd9, 1'b0, 1'b1);
        expect_result("post_rst", 32'd9, 32'd9, 32'd1);

        // 6: back-to-back frames with valid and ready held high
        idx = 0; nres = 0; bubbles = 0; cyc = 0;
        bus.out_ready = 1'b1;
        while (nres < 3 && cyc < 60) begin
            bus.in_valid  = (idx < 12);
            bus.in_data   = (idx < 12) ? b2b_data[idx] : 32'd0;
            bus.in_last   = (idx < 12) ? b2b_last[idx] : 1'b0;
            bus.in_signed = 1'b0;
            if (bus.out_valid) begin
                check("b2b_min",   bus.out_min,        b2b_exp[nres][0]);
                check("b2b_max",   bus.out_max,        b2b_exp[nres][1]);
                check("b2b_count", 32'(bus.out_count), b2b_exp[nres][2]);
                nres++;
            end
            if (!bus.in_ready) bubbles++;
            if (bus.in_valid && bus.in_ready) idx++;
            cyc++;
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        check("b2b_results", 32'(nres),    32'd3);
        check("b2b_bubbles", 32'(bubbles), 32'd3);
        check("b2b_samples", 32'(idx),     32'd12);
        check("b2b_cycles",  32'(cyc),     32'd15);
        check("b2b_idle",    32'(bus.in_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_minmax_tracker
